hms_clock_ctrl: RTL and testbench
=================================

// Module: hms_clock_ctrl
// PURPOSE
//   Time-of-day core for the six-digit watch display: 24 h hh:mm:ss counter with a push-button set mode.
//   Feeds the seven-segment decode/scan chain: o_digits goes to six fnd_dec instances, o_six_dp to the scanner dp input.
//   Replaces the free-running 0~59 counter path.
// PARAMETERS
//   TICK_DIV  50000000  clk cycles per second tick (>=2)
//   DEB_CYC   500000    cycles a synchronized button level must be stable before accepted (>=1)
// PORTS
//   clk        in   1   system clock (50 MHz)
//   rst        in   1   synchronous reset, active-high
//   i_sw_mode  in   1   raw button: toggle CLOCK/SET mode
//   i_sw_pos   in   1   raw button: select field to set (SEC->MIN->HOUR)
//   i_sw_inc   in   1   raw button: increment selected field
//   o_sec      out  6   seconds, binary 0..59
//   o_min      out  6   minutes, binary 0..59
//   o_hour     out  5   hours, binary 0..23
//   o_digits   out  24  BCD {h10,h1,m10,m1,s10,s1}, s1 in [3:0]
//   o_six_dp   out  6   dp per digit, bit0 = s1 ... bit5 = h10
//   o_mode     out  1   0 = CLOCK, 1 = SET
// BEHAVIOUR
//   Reset (rst high at clk edge): time 00:00:00, mode CLOCK, field SEC, prescaler 0, sync/debounce state 0.
//   All outputs are 0 after reset. Reset mid-set discards any partial edit.
//   Buttons: 2-flop sync per input. Debounce counter per button.
//     The accepted level updates only after the synced level differs from it for DEB_CYC consecutive cycles.
//     Press = one-cycle pulse on a 0->1 transition of the accepted level; release produces nothing.
//     A held button gives exactly one press.
//     The press pulse occurs between DEB_CYC+2 and DEB_CYC+4 cycles after the raw rise.
//   Prescaler: counts 0..TICK_DIV-1. Tick pulse in the cycle where cnt==TICK_DIV-1; the counter then wraps to 0.
//     The prescaler is forced to 0 in SET mode, so the first tick after exit arrives TICK_DIV cycles later.
//   FSM states CLOCK, SET; field register SEC/MIN/HOUR.
//     CLOCK, on tick: sec+1.
//       sec 59->0 carries to min+1; min 59->0 carries to hour+1; hour 23->0 wraps.
//       23:59:59 + tick = 00:00:00 in one cycle.
//     CLOCK, on mode press: go to SET with field=SEC. A tick in the same cycle is still applied first.
//     CLOCK: pos and inc presses are ignored.
//     SET: ticks have no effect (time frozen).
//       pos press: field SEC->MIN->HOUR->SEC.
//       inc press: selected field +1 with wrap (sec/min 59->0, hour 23->0), no carry into other fields.
//       mode press: return to CLOCK; field value is kept.
//     Simultaneous presses, same cycle: priority mode > pos > inc; lower-priority presses in that cycle are dropped.
//   Counter updates occur on the clk edge after the press/tick pulse.
//     o_sec/o_min/o_hour/o_mode are registers.
//     o_digits is combinational from the counters (/10, %10 per field), so digits follow counters with zero added latency.
//     Counters never take illegal values: sec,min <=59, hour <=23.
//   o_six_dp: CLOCK = 6'b000000.
//     SET = two bits of the selected field high (SEC 6'b000011, MIN 6'b001100, HOUR 6'b110000).
// TESTING (bench overrides TICK_DIV=10, DEB_CYC=4)
//   Reset: hold rst 3 cycles with buttons high.
//     -> all outputs 0, o_mode=0; no press actions until buttons are released and re-pressed.
//   Rollover: set 23:59:58 via SET, exit, run 20 cycles -> 23:59:59 then 00:00:00, o_digits=24'h000000, no glitch value.
//   Field wrap: in SET with field SEC at 59, inc press -> sec=0, min/hour unchanged.
//     pos x3 then inc -> field back to SEC, sec=1.
//   Debounce: i_sw_inc high 3 cycles -> no change.
//     High 200 cycles -> exactly one increment, within DEB_CYC+4 cycles of the rise.
//     0/1 toggling each cycle -> no increment.
//   Freeze/resume: enter SET at 00:00:05, wait 100 cycles -> still 00:00:05.
//     Exit -> sec=6 exactly 10 cycles (+1 edge) after o_mode falls.
//   Priority: in SET, mode and inc rise together -> o_mode=0, selected field unchanged.
//     In CLOCK, tick and mode press same cycle -> sec+1 and o_mode=1.

Source files
------------

// File: rtl/hms_clock_ctrl_if.sv
// Button inputs and display-side outputs of the hh:mm:ss time-of-day core.
// The slave side is the clock core; the master side drives buttons and watches the display values.
interface hms_clock_ctrl_if;
    logic        i_sw_mode;
    logic        i_sw_pos;
    logic        i_sw_inc;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic [4:0]  o_hour;
    logic [23:0] o_digits;
    logic [5:0]  o_six_dp;
    logic        o_mode;

    modport master (
        output i_sw_mode, i_sw_pos, i_sw_inc,
        input  o_sec, o_min, o_hour, o_digits, o_six_dp, o_mode
    );

    modport slave (
        input  i_sw_mode, i_sw_pos, i_sw_inc,
        output o_sec, o_min, o_hour, o_digits, o_six_dp, o_mode
    );
endinterface

// File: rtl/hms_clock_ctrl.sv
// 24 h hh:mm:ss time-of-day counter with a three-button SET mode (debounced raw buttons).
// Digits are BCD straight from the counter registers; dp marks the field being edited.
module hms_clock_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int DEB_CYC  = 500000
) (
    input logic             clk,
    input logic             rst,
    hms_clock_ctrl_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);

    typedef enum logic {
        ST_CLOCK = 1'b0,
        ST_SET   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2
    } field_t;

    state_t        state_reg;
    field_t        field_reg;
    logic [5:0]    sec_reg;
    logic [5:0]    min_reg;
    logic [4:0]    hour_reg;
    logic [5:0]    dp_reg;
    logic [PW-1:0] pre_cnt_reg;
    logic          tick;
    logic [2:0]    sw_raw;
    logic [2:0]    press;

    // bit 0 = mode, bit 1 = pos, bit 2 = inc; index order is also press priority
    assign sw_raw = {bus.i_sw_inc, bus.i_sw_pos, bus.i_sw_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic          sync1_reg;
            logic          sync2_reg;
            logic          acc_reg;
            logic          acc_d_reg;
            logic [DW-1:0] deb_cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    acc_reg     <= 1'b0;
                    acc_d_reg   <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    sync1_reg <= sw_raw[gi];
                    sync2_reg <= sync1_reg;
                    acc_d_reg <= acc_reg;
                    // any cycle where the synced level agrees restarts the stability count
                    if (sync2_reg == acc_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        acc_reg     <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = acc_reg & ~acc_d_reg;
        end
    endgenerate

    assign tick = (state_reg == ST_CLOCK) && (pre_cnt_reg == TICK_LAST);

    // held at zero while editing so the first second after resuming is a full one
    always_ff @(posedge clk) begin
        if (rst || (state_reg == ST_SET) || (pre_cnt_reg == TICK_LAST)) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    function automatic logic [5:0] wrap60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLOCK;
            field_reg <= FLD_SEC;
            sec_reg   <= 6'd0;
            min_reg   <= 6'd0;
            hour_reg  <= 5'd0;
            dp_reg    <= 6'd0;
        end else begin
            case (state_reg)
                ST_CLOCK: begin
                    if (tick) begin
                        sec_reg <= wrap60(sec_reg);
                        if (sec_reg == 6'd59) begin
                            min_reg <= wrap60(min_reg);
                            if (min_reg == 6'd59) begin
                                hour_reg <= wrap24(hour_reg);
                            end
                        end
                    end
                    // a tick landing with the mode press is still counted above
                    if (press[0]) begin
                        state_reg <= ST_SET;
                        field_reg <= FLD_SEC;
                        dp_reg    <= 6'b000011;
                    end
                end
                ST_SET: begin
                    if (press[0]) begin
                        state_reg <= ST_CLOCK;
                        dp_reg    <= 6'b000000;
                    end else if (press[1]) begin
                        case (field_reg)
                            FLD_SEC: begin
                                field_reg <= FLD_MIN;
                                dp_reg    <= 6'b001100;
                            end
                            FLD_MIN: begin
                                field_reg <= FLD_HOUR;
                                dp_reg    <= 6'b110000;
                            end
                            default: begin
                                field_reg <= FLD_SEC;
                                dp_reg    <= 6'b000011;
                            end
                        endcase
                    end else if (press[2]) begin
                        case (field_reg)
                            FLD_SEC:  sec_reg  <= wrap60(sec_reg);
                            FLD_MIN:  min_reg  <= wrap60(min_reg);
                            default:  hour_reg <= wrap24(hour_reg);
                        endcase
                    end
                end
                default: begin
                    state_reg <= ST_CLOCK;
                end
            endcase
        end
    end

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = v / 6'd10;
        ones = v % 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    assign bus.o_sec    = sec_reg;
    assign bus.o_min    = min_reg;
    assign bus.o_hour   = hour_reg;
    assign bus.o_digits = {to_bcd({1'b0, hour_reg}), to_bcd(min_reg), to_bcd(sec_reg)};
    assign bus.o_six_dp = dp_reg;
    assign bus.o_mode   = (state_reg == ST_SET);
endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Randomized bench for hms_clock_ctrl; the reference keeps time as seconds-of-day and
// accepts a press anywhere inside its allowed latency window.
`timescale 1ns/1ps
module tb_hms_clock_ctrl;
    localparam int TICK_DIV = 10;
    localparam int DEB_CYC  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hms_clock_ctrl_if ifc();

    hms_clock_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // reference state: seconds of day, mode, edited field, cycles since last second
    int         m_t       = 0;
    int         m_phase   = 0;
    bit         m_mode    = 1'b0;
    int         m_field   = 0;
    logic [2:0] pend_mask = 3'b000;
    int         pend_lo   = 0;
    int         pend_hi   = 0;
    int         mode_edge = -1;
    int         spurious  = 0;

    function automatic logic [16:0] exp_hms();
        return {5'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60)};
    endfunction

    function automatic logic [23:0] exp_digits();
        int h, m, s;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [5:0] exp_dp();
        return m_mode ? 6'(3 << (2 * m_field)) : 6'd0;
    endfunction

    function automatic void bump(input int f);
        int h, m, s;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        case (f)
            0:       s = (s + 1) % 60;
            1:       m = (m + 1) % 60;
            default: h = (h + 1) % 24;
        endcase
        m_t = h * 3600 + m * 60 + s;
    endfunction

    // one clock edge; advances the reference and resolves any pending press
    task automatic cyc();
        @(posedge clk);
        #1;
        ncyc++;
        if (!m_mode) begin
            m_phase++;
            if (m_phase == TICK_DIV) begin
                m_phase = 0;
                m_t = (m_t + 1) % 86400;
            end
        end
        if (ifc.o_mode !== m_mode) begin
            if (!(pend_mask[0] && ncyc >= pend_lo && ncyc <= pend_hi)) spurious++;
            m_mode    = (ifc.o_mode === 1'b1);
            m_field   = 0;
            m_phase   = 0;
            mode_edge = ncyc;
            pend_mask = 3'b000;
        end else if (pend_mask != 3'b000 && ncyc >= pend_hi) begin
            if (pend_mask[0]) spurious++;
            else if (m_mode) begin
                if (pend_mask[1]) m_field = (m_field + 1) % 3;
                else bump(m_field);
            end
            pend_mask = 3'b000;
        end
    endtask

    task automatic start_press(input logic [2:0] mask);
        {ifc.i_sw_inc, ifc.i_sw_pos, ifc.i_sw_mode} = mask;
        pend_mask = mask;
        pend_lo   = ncyc + DEB_CYC + 3;
        pend_hi   = ncyc + DEB_CYC + 5;
    endtask

    task automatic end_press();
        {ifc.i_sw_inc, ifc.i_sw_pos, ifc.i_sw_mode} = 3'b000;
        repeat (DEB_CYC + 4) cyc();
    endtask

    task automatic press(input logic [2:0] mask);
        start_press(mask);
        repeat ($urandom_range(DEB_CYC + 6, DEB_CYC + 12)) cyc();
        end_press();
    endtask

    task automatic set_time(input int th, input int tm, input int ts);
        int tgt[3];
        int md[3];
        int cur;
        int guard;
        tgt = '{ts, tm, th};
        md  = '{60, 60, 24};
        for (int f = 0; f < 3; f++) begin
            guard = 0;
            while (m_field != f && guard < 4) begin
                press(3'b010);
                guard++;
            end
            cur = (f == 0) ? m_t % 60 : (f == 1) ? (m_t / 60) % 60 : m_t / 3600;
            repeat ((tgt[f] - cur + md[f]) % md[f]) press(3'b100);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {ifc.i_sw_inc, ifc.i_sw_pos, ifc.i_sw_mode} = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        {ifc.i_sw_inc, ifc.i_sw_pos, ifc.i_sw_mode} = 3'b000;
        m_t = 0; m_phase = 0; m_mode = 1'b0; m_field = 0; pend_mask = 3'b000;
        checks++;
        if ({ifc.o_hour, ifc.o_min, ifc.o_sec, ifc.o_digits, ifc.o_six_dp, ifc.o_mode} !== 48'd0)
            begin errors++; $display("FAIL reset_outputs: got %h want 0",
                {ifc.o_hour, ifc.o_min, ifc.o_sec, ifc.o_digits, ifc.o_six_dp, ifc.o_mode}); end
        for (int i = 0; i < 25; i++) begin
            cyc();
            checks++;
            if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms() || ifc.o_mode !== 1'b0)
                begin errors++; $display("FAIL reset_run cyc %0d: got %h mode %b want %h mode 0",
                    i, {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_mode, exp_hms()); end
        end
        $display("reset: time %h after 25 cycles", {ifc.o_hour, ifc.o_min, ifc.o_sec});
    endtask

    task automatic test_rollover();
        int i;
        press(3'b001);
        checks++;
        if (ifc.o_mode !== 1'b1 || ifc.o_six_dp !== 6'b000011)
            begin errors++; $display("FAIL enter_set: got mode %b dp %b want 1 000011", ifc.o_mode, ifc.o_six_dp); end
        set_time(23, 59, 58);
        checks++;
        if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== {5'd23, 6'd59, 6'd58} || ifc.o_digits !== 24'h235958)
            begin errors++; $display("FAIL set_235958: got %h digits %h", {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_digits); end
        press(3'b001);
        i = 0;
        while (m_t != 0 && i < 40) begin
            cyc();
            i++;
            checks++;
            if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms() || ifc.o_digits !== exp_digits())
                begin errors++; $display("FAIL rollover_run: got %h digits %h want %h digits %h",
                    {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_digits, exp_hms(), exp_digits()); end
        end
        checks++;
        if (ifc.o_digits !== 24'h000000 || {ifc.o_hour, ifc.o_min, ifc.o_sec} !== 17'd0 || ifc.o_mode !== 1'b0)
            begin errors++; $display("FAIL rollover_zero: got digits %h mode %b want 000000 0", ifc.o_digits, ifc.o_mode); end
        $display("rollover: digits %h after %0d cycles", ifc.o_digits, i);
    endtask

    task automatic test_field_wrap();
        press(3'b001);
        repeat ((59 - m_t % 60 + 60) % 60) press(3'b100);
        checks++;
        if (ifc.o_sec !== 6'd59)
            begin errors++; $display("FAIL wrap_pre: got sec %0d want 59", ifc.o_sec); end
        press(3'b100);
        checks++;
        if (ifc.o_sec !== 6'd0 || {ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms())
            begin errors++; $display("FAIL wrap_sec: got %h want %h (sec 0)", {ifc.o_hour, ifc.o_min, ifc.o_sec}, exp_hms()); end
        repeat (3) press(3'b010);
        press(3'b100);
        checks++;
        if (ifc.o_sec !== 6'd1 || ifc.o_six_dp !== 6'b000011 || {ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms())
            begin errors++; $display("FAIL pos_cycle: got sec %0d dp %b want 1 000011", ifc.o_sec, ifc.o_six_dp); end
        $display("field_wrap: sec %0d dp %b", ifc.o_sec, ifc.o_six_dp);
    endtask

    task automatic test_debounce();
        logic [5:0] prev;
        int changes, first, r;
        ifc.i_sw_inc = 1'b1;
        repeat (3) cyc();
        ifc.i_sw_inc = 1'b0;
        repeat (20) cyc();
        checks++;
        if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms())
            begin errors++; $display("FAIL deb_short: got %h want %h", {ifc.o_hour, ifc.o_min, ifc.o_sec}, exp_hms()); end

        prev = ifc.o_sec; changes = 0; first = -1; r = ncyc;
        ifc.i_sw_inc = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (ifc.o_sec !== prev) begin
                changes++;
                if (first < 0) first = ncyc;
                prev = ifc.o_sec;
            end
        end
        ifc.i_sw_inc = 1'b0;
        repeat (DEB_CYC + 6) cyc();
        bump(0);
        checks++;
        if (changes !== 1 || first < r + DEB_CYC + 3 || first > r + DEB_CYC + 5)
            begin errors++; $display("FAIL deb_long: got %0d changes at +%0d want 1 at +%0d..+%0d",
                changes, first - r, DEB_CYC + 3, DEB_CYC + 5); end
        checks++;
        if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms())
            begin errors++; $display("FAIL deb_long_val: got %h want %h", {ifc.o_hour, ifc.o_min, ifc.o_sec}, exp_hms()); end

        changes = 0;
        for (int i = 0; i < 40; i++) begin
            ifc.i_sw_inc = ~ifc.i_sw_inc;
            cyc();
            if (ifc.o_sec !== prev) changes++;
        end
        ifc.i_sw_inc = 1'b0;
        repeat (DEB_CYC + 6) cyc();
        checks++;
        if (changes !== 0 || {ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms())
            begin errors++; $display("FAIL deb_toggle: got %0d changes time %h want 0 %h",
                changes, {ifc.o_hour, ifc.o_min, ifc.o_sec}, exp_hms()); end
        $display("debounce: sec %0d", ifc.o_sec);
    endtask

    task automatic test_random_edit();
        logic [2:0] masks [3];
        logic [2:0] mk;
        masks = '{3'b010, 3'b100, 3'b110};
        for (int i = 0; i < 24; i++) begin
            mk = masks[$urandom_range(0, 2)];
            press(mk);
            checks++;
            if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms() || ifc.o_six_dp !== exp_dp() || ifc.o_mode !== 1'b1)
                begin errors++; $display("FAIL rand_edit %0d mask %b: got %h dp %b want %h dp %b",
                    i, mk, {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_six_dp, exp_hms(), exp_dp()); end
            $display("edit %0d mask %b: time %h dp %b", i, mk, {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_six_dp);
        end
    endtask

    task automatic test_freeze_resume();
        int seen9, seen10;
        if (!m_mode) press(3'b001);
        set_time(0, 0, 5);
        repeat (100) cyc();
        checks++;
        if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== {5'd0, 6'd0, 6'd5})
            begin errors++; $display("FAIL freeze: got %h want 00:00:05", {ifc.o_hour, ifc.o_min, ifc.o_sec}); end
        mode_edge = -1; seen9 = 0; seen10 = 0;
        start_press(3'b001);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (i == DEB_CYC + 8) ifc.i_sw_mode = 1'b0;
            if (mode_edge >= 0 && ncyc == mode_edge + TICK_DIV - 1) begin
                seen9 = 1;
                checks++;
                if (ifc.o_sec !== 6'd5)
                    begin errors++; $display("FAIL resume_early: got sec %0d want 5", ifc.o_sec); end
            end
            if (mode_edge >= 0 && ncyc == mode_edge + TICK_DIV) begin
                seen10 = 1;
                checks++;
                if (ifc.o_sec !== 6'd6 || ifc.o_mode !== 1'b0)
                    begin errors++; $display("FAIL resume_tick: got sec %0d mode %b want 6 0", ifc.o_sec, ifc.o_mode); end
            end
        end
        checks++;
        if (seen9 + seen10 != 2)
            begin errors++; $display("FAIL resume_timeout: got %0d of 2 observation points want 2", seen9 + seen10); end
        $display("freeze_resume: mode fell at cycle %0d, sec %0d", mode_edge, ifc.o_sec);
    endtask

    task automatic test_priority();
        logic [16:0] held;
        int seen;
        press(3'b001);
        held = exp_hms();
        seen = 0;
        start_press(3'b101);
        for (int i = 0; i < DEB_CYC + 10; i++) begin
            cyc();
            if (!seen && ifc.o_mode === 1'b0) begin
                seen = 1;
                checks++;
                if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== held)
                    begin errors++; $display("FAIL prio_set: got %h want %h", {ifc.o_hour, ifc.o_min, ifc.o_sec}, held); end
            end
        end
        end_press();
        checks++;
        if (!seen || ifc.o_mode !== 1'b0 || {ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms())
            begin errors++; $display("FAIL prio_set_exit: got mode %b time %h want 0 %h",
                ifc.o_mode, {ifc.o_hour, ifc.o_min, ifc.o_sec}, exp_hms()); end

        // line the press up so its earliest landing edge is also a tick edge
        for (int i = 0; i < 3 * TICK_DIV && m_phase != TICK_DIV - (DEB_CYC + 3); i++) cyc();
        seen = 0;
        start_press(3'b001);
        for (int i = 0; i < DEB_CYC + 10; i++) begin
            cyc();
            if (!seen && ifc.o_mode === 1'b1) begin
                seen = 1;
                checks++;
                if ({ifc.o_hour, ifc.o_min, ifc.o_sec} !== exp_hms() || ifc.o_six_dp !== 6'b000011)
                    begin errors++; $display("FAIL prio_tick_mode: got %h dp %b want %h dp 000011",
                        {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_six_dp, exp_hms()); end
            end
        end
        end_press();
        checks++;
        if (!seen)
            begin errors++; $display("FAIL prio_tick_timeout: got mode %b want 1", ifc.o_mode); end
        $display("priority: time %h mode %b", {ifc.o_hour, ifc.o_min, ifc.o_sec}, ifc.o_mode);
    endtask

    initial begin
        {ifc.i_sw_inc, ifc.i_sw_pos, ifc.i_sw_mode} = 3'b000;
        test_reset();
        test_rollover();
        test_field_wrap();
        test_debounce();
        test_random_edit();
        test_freeze_resume();
        test_priority();
        checks++;
        if (spurious !== 0)
            begin errors++; $display("FAIL mode_timing: got %0d out-of-window mode changes want 0", spurious); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
